sram_responder: RTL and testbench
=================================

SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all logic on rising edge.
REQ-002 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port chip_sel, input, 1 bit: access qualifier from the initiator.
REQ-004 SHALL have port wr_en, input, 1 bit: write strobe, sampled when chip_sel=1.
REQ-005 SHALL have port rd_en, input, 1 bit: read strobe, sampled when chip_sel=1.
REQ-006 SHALL have port address, input, 11 bits: word address, 0..2047.
REQ-007 SHALL have port data_in, input, 16 bits: write data.
REQ-008 SHALL have port data_out, output, 16 bits: read data.
REQ-009 SHALL have port rd_valid, output, 1 bit: data_out valid, one-cycle pulse.
REQ-010 SHALL have port uninit_rd, output, 1 bit: pulse with rd_valid when the word read was never written.
REQ-011 SHALL have port proto_err, output, 1 bit: sticky protocol-violation flag.
REQ-012 SHALL have port session_done, output, 1 bit: one-cycle pulse when a chip_sel session ends.
REQ-013 SHALL have ports wr_count and rd_count, output, 12 bits each: accepted-access counters.

Function
REQ-014 SHALL store 2048 x 16-bit words plus a 2048-bit written-flag bitmap.
REQ-015 SHALL perform a write at the edge where chip_sel=1, wr_en=1, rd_en=0: store data_in at address and set that address's written flag.
REQ-016 SHALL perform a read at the edge where chip_sel=1, rd_en=1, wr_en=0, and present data_out and rd_valid=1 exactly one cycle later.
REQ-017 SHALL return the stored word on a read issued the cycle after a write to the same address (write-then-read; no stale data).
REQ-018 SHALL return data_out=16'h0000 with uninit_rd=1 when reading an address whose written flag is clear.
REQ-019 SHALL hold data_out at its last value while rd_valid=0.
REQ-020 SHALL treat wr_en=1 and rd_en=1 in the same cycle with chip_sel=1 as a violation: no memory access, no count, proto_err set.
REQ-021 SHALL treat wr_en=1 or rd_en=1 while chip_sel=0 as a violation: ignored, proto_err set.
REQ-022 SHALL implement FSM states IDLE and ACTIVE: IDLE->ACTIVE when chip_sel=1; ACTIVE->IDLE when chip_sel=0, pulsing session_done in the transition cycle.
REQ-023 SHALL honour an access in the cycle chip_sel first rises; the FSM state does not gate accesses.
REQ-024 SHALL increment wr_count and rd_count per accepted access and saturate at 4095, with no wrap.
REQ-025 SHALL wrap nothing on address; the address field covers the full 2048 depth.

Reset
REQ-026 SHALL on reset_n=0 asynchronously clear data_out, rd_valid, uninit_rd, proto_err, session_done, counters, the written-flag bitmap, and set FSM=IDLE.
REQ-027 SHALL leave memory array contents unreset; the cleared bitmap makes stale contents unreadable.
REQ-028 SHALL cancel a read in flight when reset asserts mid-operation, with no rd_valid after release.
REQ-029 SHALL clear proto_err only by reset.

Configuration
REQ-030 SHALL, with SRAM_RESP_STATS_EN defined, implement wr_count/rd_count per REQ-024.
REQ-031 SHALL, without SRAM_RESP_STATS_EN, keep the count ports present and tie them to 0 with no counter flops.

Structure
REQ-032 SHALL take ADDR_W=11, DATA_W=16, DEPTH=2048, CNT_W=12 and the FSM state enum from package sram_resp_pkg.
REQ-033 SHALL place the storage array in sub-module sram_resp_mem (1 write port, 1 registered read port); bitmap, FSM, flags and counters stay in sram_responder.

Verification
REQ-034 SHALL verify write/read: write 16'hA5A5 to 11'h005, read 11'h005 next cycle -> rd_valid one cycle later, data_out=16'hA5A5, uninit_rd=0.
REQ-035 SHALL verify uninitialised read: after reset, read 11'h123 -> data_out=16'h0000, uninit_rd=1, rd_valid=1.
REQ-036 SHALL verify collision: wr_en=rd_en=1 at 11'h010 with data 16'h1111 -> proto_err=1, no rd_valid, later read of 11'h010 gives uninit_rd=1, counters unchanged.
REQ-037 SHALL verify a full sweep: alternating write/read over 11'h000..11'h7FF then chip_sel drop -> all reads match, wr_count=rd_count=2048, single session_done pulse.
REQ-038 SHALL verify reset mid-read: assert reset_n=0 in the cycle after rd_en -> no rd_valid, all outputs 0, prior written data reads back with uninit_rd=1.

Source files
------------

// File: rtl/sram_resp_pkg.sv
// Shared sizing constants and FSM state type for the SRAM responder slice.
package sram_resp_pkg;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 2048;
    localparam int CNT_W  = 12;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

endpackage

// File: rtl/sram_resp_if.sv
// Initiator/responder bus bundle for the SRAM responder.
interface sram_resp_if;
    import sram_resp_pkg::*;

    logic              chip_sel;
    logic              wr_en;
    logic              rd_en;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              rd_valid;
    logic              uninit_rd;
    logic              proto_err;
    logic              session_done;
    logic [CNT_W-1:0]  wr_count;
    logic [CNT_W-1:0]  rd_count;

    modport master (
        output chip_sel, wr_en, rd_en, address, data_in,
        input  data_out, rd_valid, uninit_rd, proto_err, session_done, wr_count, rd_count
    );

    modport slave (
        input  chip_sel, wr_en, rd_en, address, data_in,
        output data_out, rd_valid, uninit_rd, proto_err, session_done, wr_count, rd_count
    );

endinterface

// File: rtl/sram_resp_mem.sv
// 2048 x 16 storage: one write port and one registered read port.
module sram_resp_mem
    import sram_resp_pkg::*;
(
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array and its read register have no reset so they map onto an SRAM macro;
    // validity is tracked by the written-flag bitmap in the parent instead.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/sram_responder.sv
// SRAM responder: access decode, written-flag bitmap, session FSM, sticky protocol flag.
// Define SRAM_RESP_STATS_EN to build the saturating access counters; otherwise they read 0.
module sram_responder
    import sram_resp_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    sram_resp_if.slave bus
);

    logic              wr_acc;
    logic              rd_acc;
    logic              violation;
    logic [DATA_W-1:0] mem_q;
    logic [DATA_W-1:0] last_data;
    logic [DATA_W-1:0] data_out_c;
    logic [DEPTH-1:0]  written;
    logic              rd_valid_q;
    logic              uninit_q;
    logic              proto_q;
    logic              session_q;
    logic              session_end;
    state_t            state_q;
    state_t            state_d;

    assign wr_acc    = bus.chip_sel & bus.wr_en & ~bus.rd_en;
    assign rd_acc    = bus.chip_sel & bus.rd_en & ~bus.wr_en;
    assign violation = (bus.chip_sel & bus.wr_en & bus.rd_en) |
                       (~bus.chip_sel & (bus.wr_en | bus.rd_en));

    sram_resp_mem u_mem (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (bus.address),
        .wr_data (bus.data_in),
        .rd_en   (rd_acc),
        .rd_addr (bus.address),
        .rd_data (mem_q)
    );

    // Never-written words read as zero; outside a valid cycle the last result is held.
    assign data_out_c = rd_valid_q ? (uninit_q ? '0 : mem_q) : last_data;

    // NOTE: all state below updates with non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            written    <= '0;
            rd_valid_q <= 1'b0;
            uninit_q   <= 1'b0;
            proto_q    <= 1'b0;
            last_data  <= '0;
            session_q  <= 1'b0;
            state_q    <= IDLE;
        end else begin
            if (wr_acc) written[bus.address] <= 1'b1;
            rd_valid_q <= rd_acc;
            uninit_q   <= rd_acc & ~written[bus.address];
            if (violation) proto_q <= 1'b1;
            if (rd_valid_q) last_data <= data_out_c;
            session_q  <= session_end;
            state_q    <= state_d;
        end
    end

    // NOTE: defaults first so no path through the case leaves a signal unassigned (no latch).
    always_comb begin
        state_d     = state_q;
        session_end = 1'b0;
        case (state_q)
            IDLE:   if (bus.chip_sel) state_d = ACTIVE;
            ACTIVE: if (!bus.chip_sel) begin
                state_d     = IDLE;
                session_end = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef SRAM_RESP_STATS_EN
    logic [CNT_W-1:0] wr_cnt_q;
    logic [CNT_W-1:0] rd_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            if (wr_acc && wr_cnt_q != CNT_MAX) wr_cnt_q <= wr_cnt_q + 1'b1;
            if (rd_acc && rd_cnt_q != CNT_MAX) rd_cnt_q <= rd_cnt_q + 1'b1;
        end
    end

    assign bus.wr_count = wr_cnt_q;
    assign bus.rd_count = rd_cnt_q;
`else
    assign bus.wr_count = '0;
    assign bus.rd_count = '0;
`endif

    assign bus.data_out     = data_out_c;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.uninit_rd    = uninit_q;
    assign bus.proto_err    = proto_q;
    assign bus.session_done = session_q;

endmodule

// File: tb/tb_sram_responder.sv
// Directed, table-driven bench for sram_responder plus multi-cycle corner sequences.
module tb_sram_responder;

`ifdef SRAM_RESP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef enum logic [1:0] {OP_NOP, OP_WR, OP_RD, OP_COL} op_e;

    typedef struct {
        op_e         op;
        logic [10:0] addr;
        logic [15:0] data;
        logic        exp_valid;
        logic [15:0] exp_data;
        logic        exp_uninit;
        logic        exp_proto;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   m_wr = 0;
    int   m_rd = 0;
    vec_t vecs [13];

    sram_resp_if bus ();

    sram_responder dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_cnt(input int n);
        if (!STATS) return 32'd0;
        return (n > 4095) ? 32'd4095 : 32'(n);
    endfunction

    function automatic logic [15:0] sweep_data(input logic [10:0] a);
        return {a[4:0] ^ 5'h15, a};
    endfunction

    task automatic drive(input logic cs, input logic wr, input logic rd,
                         input logic [10:0] addr, input logic [15:0] data);
        bus.chip_sel = cs;
        bus.wr_en    = wr;
        bus.rd_en    = rd;
        bus.address  = addr;
        bus.data_in  = data;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 11'h000, 16'h0000);
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        m_wr = 0;
        m_rd = 0;
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_wr_count"}, 32'(bus.wr_count), exp_cnt(m_wr));
        check({tag, "_rd_count"}, 32'(bus.rd_count), exp_cnt(m_rd));
    endtask

    initial begin
        int pulses;
        int sweep_bad;

        vecs[0]  = '{OP_WR,  11'h005, 16'hA5A5, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[1]  = '{OP_RD,  11'h005, 16'h0000, 1'b1, 16'hA5A5, 1'b0, 1'b0};
        vecs[2]  = '{OP_NOP, 11'h005, 16'h0000, 1'b0, 16'hA5A5, 1'b0, 1'b0};
        vecs[3]  = '{OP_RD,  11'h123, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[4]  = '{OP_NOP, 11'h123, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[5]  = '{OP_WR,  11'h7FF, 16'hBEEF, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[6]  = '{OP_RD,  11'h7FF, 16'h0000, 1'b1, 16'hBEEF, 1'b0, 1'b0};
        vecs[7]  = '{OP_WR,  11'h000, 16'h0001, 1'b0, 16'hBEEF, 1'b0, 1'b0};
        vecs[8]  = '{OP_RD,  11'h000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
        vecs[9]  = '{OP_COL, 11'h010, 16'h1111, 1'b0, 16'h0001, 1'b0, 1'b1};
        vecs[10] = '{OP_RD,  11'h010, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1};
        vecs[11] = '{OP_WR,  11'h005, 16'h5A5A, 1'b0, 16'h0000, 1'b0, 1'b1};
        vecs[12] = '{OP_RD,  11'h005, 16'h0000, 1'b1, 16'h5A5A, 1'b0, 1'b1};

        // Reset state, sampled while reset is held.
        drive(1'b0, 1'b0, 1'b0, 11'h000, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        check("rst_data_out", 32'(bus.data_out), 32'h0);
        check("rst_rd_valid", 32'(bus.rd_valid), 32'h0);
        check("rst_uninit", 32'(bus.uninit_rd), 32'h0);
        check("rst_proto", 32'(bus.proto_err), 32'h0);
        check("rst_session", 32'(bus.session_done), 32'h0);
        check_counts("rst");
        @(negedge clk);
        reset_n = 1'b1;

        // Table: one chip_sel session, each row is one access cycle.
        for (int i = 0; i < 13; i++) begin
            drive(1'b1, vecs[i].op inside {OP_WR, OP_COL}, vecs[i].op inside {OP_RD, OP_COL},
                  vecs[i].addr, vecs[i].data);
            cycle();
            if (vecs[i].op == OP_WR) m_wr++;
            if (vecs[i].op == OP_RD) m_rd++;
            check($sformatf("v%0d_rd_valid", i), 32'(bus.rd_valid), 32'(vecs[i].exp_valid));
            check($sformatf("v%0d_data_out", i), 32'(bus.data_out), 32'(vecs[i].exp_data));
            check($sformatf("v%0d_uninit", i), 32'(bus.uninit_rd), 32'(vecs[i].exp_uninit));
            check($sformatf("v%0d_proto", i), 32'(bus.proto_err), 32'(vecs[i].exp_proto));
            check_counts($sformatf("v%0d", i));
        end

        // Session end: exactly one session_done pulse; proto_err stays sticky.
        drive(1'b0, 1'b0, 1'b0, 11'h000, 16'h0000);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            pulses += int'(bus.session_done);
        end
        check("table_session_pulses", 32'(pulses), 32'd1);
        check("proto_sticky", 32'(bus.proto_err), 32'h1);

        // Reset clears proto_err; strobes without chip_sel are violations and ignored.
        do_reset();
        #1;
        check("proto_cleared", 32'(bus.proto_err), 32'h0);
        drive(1'b0, 1'b1, 1'b0, 11'h020, 16'h2222);
        cycle();
        check("nocs_proto", 32'(bus.proto_err), 32'h1);
        drive(1'b1, 1'b0, 1'b1, 11'h020, 16'h0000);
        cycle();
        m_rd++;
        check("nocs_rd_valid", 32'(bus.rd_valid), 32'h1);
        check("nocs_uninit", 32'(bus.uninit_rd), 32'h1);
        check("nocs_data", 32'(bus.data_out), 32'h0);
        check_counts("nocs");

        // Reset mid-read: valid read issued, reset asserted right after the sampling edge.
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 11'h0AA, 16'h1234);
        cycle();
        drive(1'b1, 1'b0, 1'b1, 11'h0AA, 16'h0000);
        cycle();
        reset_n = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 11'h0AA, 16'h0000);
        #1;
        check("midrst_rd_valid", 32'(bus.rd_valid), 32'h0);
        check("midrst_data", 32'(bus.data_out), 32'h0);
        check("midrst_uninit", 32'(bus.uninit_rd), 32'h0);
        check("midrst_proto", 32'(bus.proto_err), 32'h0);
        m_wr = 0;
        m_rd = 0;
        check_counts("midrst");
        @(negedge clk);
        reset_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            pulses += int'(bus.rd_valid);
        end
        check("midrst_no_valid", 32'(pulses), 32'd0);
        drive(1'b1, 1'b0, 1'b1, 11'h0AA, 16'h0000);
        cycle();
        m_rd++;
        check("midrst_reread_valid", 32'(bus.rd_valid), 32'h1);
        check("midrst_reread_uninit", 32'(bus.uninit_rd), 32'h1);
        check("midrst_reread_data", 32'(bus.data_out), 32'h0);

        // Full sweep: write then read every address in one session.
        do_reset();
        sweep_bad = 0;
        pulses = 0;
        for (int a = 0; a < 2048; a++) begin
            drive(1'b1, 1'b1, 1'b0, 11'(a), sweep_data(11'(a)));
            cycle();
            pulses += int'(bus.session_done);
            drive(1'b1, 1'b0, 1'b1, 11'(a), 16'h0000);
            cycle();
            pulses += int'(bus.session_done);
            if (bus.rd_valid !== 1'b1 || bus.uninit_rd !== 1'b0 ||
                bus.data_out !== sweep_data(11'(a)))
                sweep_bad++;
        end
        m_wr = 2048;
        m_rd = 2048;
        drive(1'b0, 1'b0, 1'b0, 11'h000, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            cycle();
            pulses += int'(bus.session_done);
        end
        check("sweep_bad_reads", 32'(sweep_bad), 32'd0);
        check("sweep_session_pulses", 32'(pulses), 32'd1);
        check("sweep_proto", 32'(bus.proto_err), 32'h0);
        check_counts("sweep");

        // Saturation: 2048 more writes push the write count past 4095.
        for (int a = 0; a < 2048; a++) begin
            drive(1'b1, 1'b1, 1'b0, 11'(a), 16'hFFFF);
            cycle();
        end
        m_wr += 2048;
        drive(1'b0, 1'b0, 1'b0, 11'h000, 16'h0000);
        cycle();
        check_counts("sat");
        check("sat_wr_hold", 32'(bus.wr_count), STATS ? 32'd4095 : 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
